// File: rtl/clk_tick_gen.sv
// clk_tick_gen: multi-channel programmable clock divider.
// Each channel produces a 50 % duty square wave with a half-period of D+1
// clocks, plus a one-cycle tick on every rising edge of that wave. New
// divisors are staged in a shadow register and only reach the active
// divisor at a half-period boundary, so the output never glitches.
module clk_tick_gen #(
    parameter int unsigned NUM_CH    = 3,
    parameter int unsigned CNT_W     = 26,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned DIV_RESET = 10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_data,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DIV_RESET);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_act;
        logic [CNT_W-1:0] r_shd;
        logic             r_pend;
        logic             r_clk;
        logic             r_tick;

        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] w_act_nxt;
        logic [CNT_W-1:0] w_shd_nxt;
        logic             w_pend_nxt;
        logic             w_clk_nxt;
        logic             w_tick_nxt;

        logic             w_wr;
        logic             w_tc;
        logic             w_dis_apply;
        logic             w_apply;

        // Write addressed to this channel; out-of-range selects never match.
        assign w_wr        = div_wr && (div_sel == SEL_W'(gi));
        // Terminal count: last cycle of the current half-period.
        assign w_tc        = en[gi] && (r_cnt == r_act);
        // A paused channel takes a pending divisor right away.
        assign w_dis_apply = !en[gi] && r_pend;
        // Any boundary where the shadow (or a concurrent write) lands in act.
        assign w_apply     = sync || w_tc || w_dis_apply;

        // Next-state logic for counter, divisors and outputs.
        always_comb begin
            w_cnt_nxt  = r_cnt;
            w_act_nxt  = r_act;
            w_shd_nxt  = r_shd;
            w_pend_nxt = r_pend;
            w_clk_nxt  = r_clk;
            w_tick_nxt = 1'b0;

            if (w_apply) begin
                if (w_wr) begin
                    w_act_nxt = div_data;
                    w_shd_nxt = div_data;
                end else if (r_pend) begin
                    w_act_nxt = r_shd;
                end
                w_pend_nxt = 1'b0;
            end else if (w_wr) begin
                w_shd_nxt  = div_data;
                w_pend_nxt = 1'b1;
            end

            if (sync) begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
            end else if (w_tc) begin
                w_cnt_nxt  = '0;
                w_clk_nxt  = !r_clk;
                w_tick_nxt = !r_clk;
            end else if (en[gi]) begin
                // cnt < act here, so the increment cannot wrap.
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end else if (r_pend) begin
                w_cnt_nxt = '0;
            end
        end

        // Channel state registers with asynchronous reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt  <= '0;
                r_act  <= RST_DIV;
                r_shd  <= RST_DIV;
                r_pend <= 1'b0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
            end else begin
                r_cnt  <= w_cnt_nxt;
                r_act  <= w_act_nxt;
                r_shd  <= w_shd_nxt;
                r_pend <= w_pend_nxt;
                r_clk  <= w_clk_nxt;
                r_tick <= w_tick_nxt;
            end
        end

        assign clk_out[gi] = r_clk;
        assign tick[gi]    = r_tick;
        assign pend[gi]    = r_pend;
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Testbench for clk_tick_gen: directed scenarios plus randomized traffic,
// all checked against a countdown-based behavioural model of each channel.
module tb_clk_tick_gen;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned DIV_RST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic              sync = 1'b0;
    logic              div_wr = 1'b0;
    logic [SEL_W-1:0]  div_sel = '0;
    logic [CNT_W-1:0]  div_data = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pend;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: remaining edges until next toggle, per channel.
    int m_rem [NUM_CH];
    int m_act [NUM_CH];
    int m_shd [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_lvl [NUM_CH];
    bit m_tick[NUM_CH];

    clk_tick_gen #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W), .DIV_RESET(DIV_RST)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .div_wr(div_wr),
        .div_sel(div_sel), .div_data(div_data),
        .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_act[c]  = DIV_RST;
            m_shd[c]  = DIV_RST;
            m_rem[c]  = DIV_RST + 1;
            m_pend[c] = 0;
            m_lvl[c]  = 0;
            m_tick[c] = 0;
        end
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic m_edge();
        bit wr;
        bit bnd;
        for (int c = 0; c < NUM_CH; c++) begin
            wr  = div_wr && (int'(div_sel) == c);
            bnd = 0;
            m_tick[c] = 0;
            if (sync) begin
                m_lvl[c] = 0;
                bnd = 1;
            end else if (en[c]) begin
                if (m_rem[c] == 1) begin
                    m_lvl[c]  = !m_lvl[c];
                    m_tick[c] = m_lvl[c];
                    bnd = 1;
                end else begin
                    m_rem[c]--;
                end
            end else begin
                bnd = m_pend[c];
            end
            if (bnd) begin
                if (wr) begin
                    m_act[c] = int'(div_data);
                    m_shd[c] = int'(div_data);
                end else if (m_pend[c]) begin
                    m_act[c] = m_shd[c];
                end
                m_pend[c] = 0;
                m_rem[c]  = m_act[c] + 1;
            end else if (wr) begin
                m_shd[c]  = int'(div_data);
                m_pend[c] = 1;
            end
        end
    endtask

    // Advance one edge, update model, compare all outputs 1 time unit later.
    task automatic step();
        logic [NUM_CH-1:0] e_clk, e_tick, e_pend;
        @(posedge clk);
        if (rst) m_reset();
        else m_edge();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            e_clk[c]  = m_lvl[c];
            e_tick[c] = m_tick[c];
            e_pend[c] = m_pend[c];
        end
        check("clk_out", 32'(clk_out), 32'(e_clk));
        check("tick",    32'(tick),    32'(e_tick));
        check("pend",    32'(pend),    32'(e_pend));
    endtask

    // Assert reset between edges, verify immediate clear, then release.
    task automatic do_reset();
        #3;
        rst = 1'b1;
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_pend",    32'(pend),    32'd0);
        m_reset();
        step();
        rst = 1'b0;
    endtask

    task automatic write(input int sel, input int data);
        div_wr   = 1'b1;
        div_sel  = SEL_W'(sel);
        div_data = CNT_W'(data);
        step();
        div_wr   = 1'b0;
    endtask

    initial begin
        int q[$];
        int rise_e, fall_e, first_e [NUM_CH];
        int n_tick, n_tog, waited;
        logic prev;

        m_reset();

        // Reset release: rise at 5, fall at 10, ticks at 5/15/25.
        do_reset();
        en = 3'b111;
        rise_e = 0; fall_e = 0;
        for (int e = 1; e <= 26; e++) begin
            step();
            if (tick[0]) q.push_back(e);
            if (clk_out[0] && rise_e == 0) rise_e = e;
            if (!clk_out[0] && rise_e != 0 && fall_e == 0) fall_e = e;
        end
        check("rel_rise", 32'(rise_e), 32'd5);
        check("rel_fall", 32'(fall_e), 32'd10);
        check("rel_nticks", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            check("rel_tick0", 32'(q[0]), 32'd5);
            check("rel_tick1", 32'(q[1]), 32'd15);
            check("rel_tick2", 32'(q[2]), 32'd25);
        end

        // Mid-period write on ch1 while cnt=2.
        do_reset();
        en = 3'b111;
        step(); step();
        write(1, 1);
        check("mid_pend_e3", 32'(pend[1]), 32'd1);
        step();
        check("mid_pend_e4", 32'(pend[1]), 32'd1);
        step();
        check("mid_pend_e5", 32'(pend[1]), 32'd0);
        check("mid_rise_e5", 32'(clk_out[1]), 32'd1);
        step();
        check("mid_hold_e6", 32'(clk_out[1]), 32'd1);
        step();
        check("mid_fall_e7", 32'(clk_out[1]), 32'd0);
        step(); step();
        check("mid_rise_e9", 32'(clk_out[1]), 32'd1);

        // Pause ch2 for 7 cycles mid-half-period.
        do_reset();
        en = 3'b111;
        for (int e = 1; e <= 7; e++) step();
        en = 3'b011;
        for (int e = 8; e <= 14; e++) step();
        check("pause_frozen", 32'(clk_out[2]), 32'd1);
        en = 3'b111;
        q.delete();
        for (int e = 15; e <= 35; e++) begin
            step();
            if (tick[2]) q.push_back(e);
        end
        check("pause_nticks", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            check("pause_tick0", 32'(q[0]), 32'd22);
            check("pause_tick1", 32'(q[1]), 32'd32);
        end

        // Sync with D=2,4,4 after phases diverge.
        write(0, 2);
        write(1, 4);
        write(2, 4);
        en = 3'b101;
        for (int k = 0; k < 4; k++) step();
        en = 3'b111;
        for (int k = 0; k < 3; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_clk", 32'(clk_out), 32'd0);
        check("sync_pend", 32'(pend), 32'd0);
        for (int c = 0; c < NUM_CH; c++) first_e[c] = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++)
                if (clk_out[c] && first_e[c] == 0) first_e[c] = k;
        end
        check("sync_rise0", 32'(first_e[0]), 32'd3);
        check("sync_rise1", 32'(first_e[1]), 32'd5);
        check("sync_rise2", 32'(first_e[2]), 32'd5);

        // Out-of-range select is ignored.
        write(3, 0);
        check("badsel_pend", 32'(pend), 32'd0);

        // D=0 on ch0: toggle every cycle, tick every two.
        write(0, 0);
        waited = 0;
        while (pend[0] && waited < 20) begin
            step();
            waited++;
        end
        check("d0_applied", 32'(pend[0]), 32'd0);
        step();
        n_tick = 0; n_tog = 0; prev = clk_out[0];
        for (int k = 0; k < 10; k++) begin
            step();
            if (tick[0]) n_tick++;
            if (clk_out[0] != prev) n_tog++;
            prev = clk_out[0];
        end
        check("d0_ticks", 32'(n_tick), 32'd5);
        check("d0_toggles", 32'(n_tog), 32'd10);

        // Write coinciding with TC lands straight in act.
        write(0, 1);
        check("tc_write_pend", 32'(pend[0]), 32'd0);

        // D=255 on ch1: 512-cycle period.
        write(1, 255);
        sync = 1'b1;
        step();
        sync = 1'b0;
        q.delete();
        for (int e = 1; e <= 800; e++) begin
            step();
            if (tick[1]) q.push_back(e);
        end
        check("d255_nticks", 32'(q.size()), 32'd2);
        if (q.size() == 2) begin
            check("d255_first", 32'(q[0]), 32'd256);
            check("d255_period", 32'(q[1] - q[0]), 32'd512);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            en = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) != 0)};
            sync     = ($urandom_range(0, 99) == 0);
            div_wr   = ($urandom_range(0, 7) == 0);
            div_sel  = SEL_W'($urandom_range(0, 3));
            div_data = ($urandom_range(0, 15) == 0) ? CNT_W'($urandom)
                                                    : CNT_W'($urandom_range(0, 6));
            step();
        end
        sync = 1'b0;
        div_wr = 1'b0;

        // Async reset mid-run: divisors return to 4.
        do_reset();
        en = 3'b111;
        for (int e = 1; e <= 5; e++) step();
        check("rst_div_clk", 32'(clk_out), 32'd7);
        check("rst_div_tick", 32'(tick), 32'd7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
